// File: rtl/pdm_playback_sdm_if.sv
// PCM sample stream into the PDM playback transmitter (valid/ready handshake).
interface pdm_playback_sdm_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic signed [DATA_WIDTH-1:0] pcm_in;
    logic                         pcm_valid;
    logic                         pcm_ready;

    modport master (output pcm_in, output pcm_valid, input  pcm_ready);
    modport slave  (input  pcm_in, input  pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_playback_sdm.sv
// PCM-to-PDM transmitter: sample FIFO, zero-order hold over OVERSAMPLE bits and a
// 2nd-order sigma-delta modulator driving pdm_clk / pdm_data.
module pdm_playback_sdm #(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned PDM_CLK_FREQ = 3_072_000,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned OVERSAMPLE   = 128,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    pdm_playback_sdm_if.slave           pcm_if,
    output logic                        pdm_clk,
    output logic                        pdm_data,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned HALF  = CLK_FREQ / (2 * PDM_CLK_FREQ);
    localparam int unsigned PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned BC_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned W     = DATA_WIDTH + 6;
    localparam int unsigned SW    = W + 2;

    localparam logic signed [W-1:0] FS_P  = {{(W-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [W-1:0] SAT_P = {1'b0, {(W-1){1'b1}}};

    // Symmetric clamp of a widened integrator sum back into W bits.
    function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] v);
        if (v > SW'(SAT_P)) begin
            return SAT_P;
        end else if (v < -SW'(SAT_P)) begin
            return -SAT_P;
        end else begin
            return W'(v);
        end
    endfunction

    logic [PH_W-1:0]               phase_q,    phase_d;
    logic                          pdm_clk_q,  pdm_clk_d;
    logic                          pdm_data_q, pdm_data_d;
    logic                          underrun_q, underrun_d;
    logic [BC_W-1:0]               bit_cnt_q,  bit_cnt_d;
    logic signed [DATA_WIDTH-1:0]  sample_q,   sample_d;
    logic signed [W-1:0]           i1_q,       i1_d;
    logic signed [W-1:0]           i2_q,       i2_d;

    logic signed [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]              level_q,    level_d;

    logic                          phase_wrap_c;
    logic                          step_c;
    logic                          fetch_c;
    logic                          full_c;
    logic                          empty_c;
    logic                          push_c;
    logic                          pop_c;
    logic signed [DATA_WIDTH-1:0]  sample_now_c;
    logic signed [W-1:0]           x_c;
    logic signed [W-1:0]           fb_c;
    logic signed [SW-1:0]          sum1_c;
    logic signed [SW-1:0]          sum2_c;
    logic signed [W-1:0]           i1_new_c;
    logic signed [W-1:0]           i2_new_c;

    // Step event = the cycle in which pdm_clk goes 1->0; all modulator state moves only here.
    assign phase_wrap_c = (phase_q == PH_W'(HALF - 1));
    assign step_c       = enable && phase_wrap_c && pdm_clk_q;
    assign fetch_c      = step_c && (bit_cnt_q == '0);

    assign full_c  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty_c = (level_q == '0);
    assign push_c  = pcm_if.pcm_valid && !full_c;
    assign pop_c   = fetch_c && !empty_c;

    assign pcm_if.pcm_ready = !full_c;

    // A fetch step modulates the freshly popped sample in that same step.
    always_comb begin
        sample_now_c = sample_q;
        if (fetch_c) begin
            sample_now_c = empty_c ? '0 : mem_q[rd_ptr_q];
        end
        x_c      = W'(sample_now_c >>> 1);
        fb_c     = pdm_data_q ? FS_P : -FS_P;
        sum1_c   = SW'(i1_q) + SW'(x_c) - SW'(fb_c);
        i1_new_c = sat_w(sum1_c);
        sum2_c   = SW'(i2_q) + SW'(i1_new_c) - SW'(fb_c);
        i2_new_c = sat_w(sum2_c);
    end

    // Clock generator, bit counter and modulator next state.
    always_comb begin
        phase_d    = phase_q;
        pdm_clk_d  = pdm_clk_q;
        pdm_data_d = pdm_data_q;
        underrun_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        sample_d   = sample_q;
        i1_d       = i1_q;
        i2_d       = i2_q;
        if (!enable) begin
            phase_d    = '0;
            pdm_clk_d  = 1'b0;
            pdm_data_d = 1'b0;
            bit_cnt_d  = '0;
            sample_d   = '0;
            i1_d       = '0;
            i2_d       = '0;
        end else begin
            if (phase_wrap_c) begin
                phase_d   = '0;
                pdm_clk_d = !pdm_clk_q;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
            if (step_c) begin
                bit_cnt_d  = (bit_cnt_q == BC_W'(OVERSAMPLE - 1)) ? '0 : bit_cnt_q + BC_W'(1);
                sample_d   = sample_now_c;
                i1_d       = i1_new_c;
                i2_d       = i2_new_c;
                pdm_data_d = !i2_new_c[W-1];
                underrun_d = fetch_c && empty_c;
            end
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= pcm_if.pcm_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            pdm_clk_q  <= 1'b0;
            pdm_data_q <= 1'b0;
            underrun_q <= 1'b0;
            bit_cnt_q  <= '0;
            sample_q   <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            phase_q    <= phase_d;
            pdm_clk_q  <= pdm_clk_d;
            pdm_data_q <= pdm_data_d;
            underrun_q <= underrun_d;
            bit_cnt_q  <= bit_cnt_d;
            sample_q   <= sample_d;
            i1_q       <= i1_d;
            i2_q       <= i2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    assign pdm_clk    = pdm_clk_q;
    assign pdm_data   = pdm_data_q;
    assign underrun   = underrun_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_pdm_playback_sdm.sv
// Self-checking bench for pdm_playback_sdm against an integer/queue reference model.
module tb_pdm_playback_sdm;

    localparam int DW    = 16;
    localparam int HALF  = 16;
    localparam int PER   = 2 * HALF;
    localparam int OS    = 128;
    localparam int DEPTH = 16;
    localparam int FS    = 32768;
    localparam int SATV  = (1 << 21) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       pdm_clk;
    logic       pdm_data;
    logic       underrun;
    logic [4:0] fifo_level;

    pdm_playback_sdm_if #(.DATA_WIDTH(DW)) ifc ();

    pdm_playback_sdm #(
        .CLK_FREQ    (100_000_000),
        .PDM_CLK_FREQ(3_072_000),
        .DATA_WIDTH  (DW),
        .OVERSAMPLE  (OS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (en),
        .pcm_if    (ifc),
        .pdm_clk   (pdm_clk),
        .pdm_data  (pdm_data),
        .underrun  (underrun),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model state: n counts enabled clk cycles, steps every PER cycles.
    int q[$];
    int m_n, m_cnt, m_cur, m_i1, m_i2;
    bit m_d, m_clk, m_under;

    function automatic int clip(input int v);
        if (v > SATV)  return SATV;
        if (v < -SATV) return -SATV;
        return v;
    endfunction

    task automatic model_clear();
        q.delete();
        m_n = 0; m_cnt = 0; m_cur = 0; m_i1 = 0; m_i2 = 0;
        m_d = 0; m_clk = 0; m_under = 0;
    endtask

    task automatic model_edge();
        bit accept;
        int x, fb;
        m_under = 0;
        if (!rst_n) begin
            model_clear();
            return;
        end
        accept = ifc.pcm_valid && (q.size() < DEPTH);
        if (en) begin
            m_n++;
            if (m_n % PER == 0) begin
                if (m_cnt == 0) begin
                    if (q.size() > 0) m_cur = q.pop_front();
                    else begin m_cur = 0; m_under = 1; end
                end
                x    = m_cur >>> 1;
                fb   = m_d ? FS : -FS;
                m_i1 = clip(m_i1 + x - fb);
                m_i2 = clip(m_i2 + m_i1 - fb);
                m_d  = (m_i2 >= 0);
                m_cnt = (m_cnt + 1) % OS;
            end
            m_clk = ((m_n / HALF) % 2) == 1;
        end else begin
            m_n = 0; m_cnt = 0; m_cur = 0; m_i1 = 0; m_i2 = 0; m_d = 0; m_clk = 0;
        end
        if (accept) q.push_back(int'(ifc.pcm_in));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        en = 0; ifc.pcm_valid = 0; rst_n = 0;
        model_clear();
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1; en = 0; ifc.pcm_valid = 0; ifc.pcm_in = '0;
        #2 rst_n = 0;
        model_clear();
        #1;
        checks++; if (pdm_clk !== 1'b0)    begin $display("FAIL reset_pdm_clk got=%b exp=0", pdm_clk); failures++; end
        checks++; if (pdm_data !== 1'b0)   begin $display("FAIL reset_pdm_data got=%b exp=0", pdm_data); failures++; end
        checks++; if (underrun !== 1'b0)   begin $display("FAIL reset_underrun got=%b exp=0", underrun); failures++; end
        checks++; if (fifo_level !== 5'd0) begin $display("FAIL reset_level got=%0d exp=0", fifo_level); failures++; end
        checks++; if (ifc.pcm_ready !== 1'b1) begin $display("FAIL reset_ready got=%b exp=1", ifc.pcm_ready); failures++; end
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_fifo();
        bit bad = 0;
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            ifc.pcm_valid = 1;
            ifc.pcm_in    = 16'($urandom);
            checks++;
            if (ifc.pcm_ready !== (q.size() < DEPTH)) begin
                $display("FAIL fifo_ready_fill i=%0d got=%b exp=%b", i, ifc.pcm_ready, q.size() < DEPTH); failures++;
            end
            tick();
            checks++;
            if (fifo_level !== 5'(q.size())) begin
                $display("FAIL fifo_level_fill i=%0d got=%0d exp=%0d", i, fifo_level, q.size()); failures++;
            end
        end
        ifc.pcm_valid = 0;
        tick();
        checks++; if (fifo_level !== 5'd16)   begin $display("FAIL fifo_full_level got=%0d exp=16", fifo_level); failures++; end
        checks++; if (ifc.pcm_ready !== 1'b0) begin $display("FAIL fifo_full_ready got=%b exp=0", ifc.pcm_ready); failures++; end
        en = 1;
        for (int c = 0; c < PER + 8 && !bad; c++) begin
            tick();
            checks++;
            if (fifo_level !== 5'(q.size()) || ifc.pcm_ready !== (q.size() < DEPTH)) begin
                $display("FAIL fifo_drain c=%0d level=%0d ready=%b exp_level=%0d", c, fifo_level, ifc.pcm_ready, q.size());
                failures++; bad = 1;
            end
        end
        checks++; if (fifo_level !== 5'd15)   begin $display("FAIL fifo_after_pop_level got=%0d exp=15", fifo_level); failures++; end
        checks++; if (ifc.pcm_ready !== 1'b1) begin $display("FAIL fifo_after_pop_ready got=%b exp=1", ifc.pcm_ready); failures++; end
    endtask

    task automatic test_pdm_clk_random();
        bit   bad = 0, seen_rise = 0;
        int   hi = 0, lo = 0;
        logic pc, pd;
        do_reset();
        en = 1;
        pc = pdm_clk; pd = pdm_data;
        for (int c = 0; c < 256 * PER && !bad; c++) begin
            ifc.pcm_valid = ($urandom_range(0, 511) == 0);
            ifc.pcm_in    = 16'($urandom);
            tick();
            checks++;
            if (pdm_clk !== m_clk || pdm_data !== m_d || underrun !== m_under || fifo_level !== 5'(q.size())) begin
                $display("FAIL rand_stream c=%0d clk=%b/%b data=%b/%b under=%b/%b level=%0d/%0d",
                         c, pdm_clk, m_clk, pdm_data, m_d, underrun, m_under, fifo_level, q.size());
                failures++; bad = 1;
            end
            if (pdm_data !== pd) begin
                checks++;
                if (!(pc === 1'b1 && pdm_clk === 1'b0)) begin
                    $display("FAIL data_not_on_fall c=%0d clk %b->%b", c, pc, pdm_clk); failures++; bad = 1;
                end
            end
            if (pc === 1'b0 && pdm_clk === 1'b1) begin
                if (seen_rise) begin
                    checks++;
                    if (lo != HALF) begin $display("FAIL clk_low_len got=%0d exp=%0d", lo, HALF); failures++; bad = 1; end
                end
                seen_rise = 1; hi = 1;
            end else if (pc === 1'b1 && pdm_clk === 1'b0) begin
                checks++;
                if (hi != HALF) begin $display("FAIL clk_high_len got=%0d exp=%0d", hi, HALF); failures++; bad = 1; end
                lo = 1;
            end else if (pdm_clk === 1'b1) hi++;
            else lo++;
            pc = pdm_clk; pd = pdm_data;
        end
        ifc.pcm_valid = 0;
    endtask

    task automatic test_dc(input int v, input string name);
        bit  bad = 0;
        int  ones = 0, pulses = 0;
        real exp_ones, diff;
        do_reset();
        ifc.pcm_in = 16'(v);
        ifc.pcm_valid = 1;
        for (int i = 0; i < DEPTH; i++) tick();
        en = 1;
        for (int c = 0; c < 512 * PER && !bad; c++) begin
            tick();
            checks++;
            if (pdm_data !== m_d || underrun !== m_under) begin
                $display("FAIL dc_%s c=%0d data=%b/%b under=%b/%b", name, c, pdm_data, m_d, underrun, m_under);
                failures++; bad = 1;
            end
            if (underrun === 1'b1) pulses++;
            if (m_n % PER == 0 && pdm_data === 1'b1) ones++;
        end
        ifc.pcm_valid = 0;
        exp_ones = 512.0 * (0.5 + real'(v >>> 1) / (2.0 * FS));
        diff = real'(ones) - exp_ones;
        checks++;
        if (diff > 8.0 || diff < -8.0) begin
            $display("FAIL dc_%s_density ones=%0d exp=%0.1f of 512", name, ones, exp_ones); failures++;
        end
        checks++;
        if (pulses != 0) begin $display("FAIL dc_%s_underrun pulses=%0d exp=0", name, pulses); failures++; end
    endtask

    task automatic test_underrun();
        bit bad = 0;
        int pulses = 0, ones = 0;
        do_reset();
        en = 1;
        for (int c = 0; c < 300 * PER && !bad; c++) begin
            tick();
            checks++;
            if (underrun !== m_under || pdm_data !== m_d) begin
                $display("FAIL underrun_stream c=%0d under=%b/%b data=%b/%b", c, underrun, m_under, pdm_data, m_d);
                failures++; bad = 1;
            end
            if (underrun === 1'b1) pulses++;
            if (m_n % PER == 0 && pdm_data === 1'b1) ones++;
        end
        checks++; if (pulses != 3) begin $display("FAIL underrun_count got=%0d exp=3", pulses); failures++; end
        checks++;
        if (ones < 142 || ones > 158) begin $display("FAIL underrun_density ones=%0d exp=150 of 300", ones); failures++; end
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        do_reset();
        ifc.pcm_valid = 1;
        for (int i = 0; i < 8; i++) begin
            ifc.pcm_in = 16'($urandom);
            tick();
        end
        ifc.pcm_valid = 0;
        en = 1;
        for (int c = 0; c < 5010 && !bad; c++) begin
            tick();
            checks++;
            if (pdm_data !== m_d || pdm_clk !== m_clk || fifo_level !== 5'(q.size())) begin
                $display("FAIL midrun c=%0d data=%b/%b clk=%b/%b level=%0d/%0d",
                         c, pdm_data, m_d, pdm_clk, m_clk, fifo_level, q.size());
                failures++; bad = 1;
            end
        end
        rst_n = 0; en = 0;
        model_clear();
        #1;
        checks++; if (pdm_clk !== 1'b0)       begin $display("FAIL midreset_pdm_clk got=%b exp=0", pdm_clk); failures++; end
        checks++; if (pdm_data !== 1'b0)      begin $display("FAIL midreset_pdm_data got=%b exp=0", pdm_data); failures++; end
        checks++; if (underrun !== 1'b0)      begin $display("FAIL midreset_underrun got=%b exp=0", underrun); failures++; end
        checks++; if (fifo_level !== 5'd0)    begin $display("FAIL midreset_level got=%0d exp=0", fifo_level); failures++; end
        checks++; if (ifc.pcm_ready !== 1'b1) begin $display("FAIL midreset_ready got=%b exp=1", ifc.pcm_ready); failures++; end
        tick();
        rst_n = 1;
        tick();
        en = 1;
        for (int c = 0; c < PER; c++) tick();
        checks++;
        if (underrun !== 1'b1) begin $display("FAIL midreset_fifo_discarded underrun got=%b exp=1", underrun); failures++; end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ifc.pcm_valid = 0;
        ifc.pcm_in = '0;
        model_clear();
        test_reset();
        test_fifo();
        test_pdm_clk_random();
        test_dc(0, "zero");
        test_dc(8192, "pos8192");
        test_dc(-32768, "neg32768");
        test_underrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
